nibble_serial_sub_ctrl: RTL and testbench

- Sequencer that reuses a single 4-bit ripple-borrow subtractor slice to compute WIDTH-bit unsigned differences a - b.
- Processes one nibble per cycle, LSB first, and holds the inter-nibble carry in a register.
- Sits between an upstream requester (valid/ready) and a downstream consumer (valid/ready).
- Replaces wide combinational subtractor chains where area matters more than latency.

---
 rtl/nibble_sub_pkg.sv | 20 ++
 rtl/sub_nibble_slice.sv | 26 ++
 rtl/nibble_serial_sub_ctrl.sv | 161 ++++++++++++++++
 tb/tb_nibble_serial_sub_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sub_pkg.sv
// Shared types and helpers for the nibble-serial subtractor controller.
package nibble_sub_pkg;

  localparam int unsigned NIB_W = 4;
  // Widest operand the nibble selector can address.
  localparam int unsigned MAX_W = 256;

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StNeg,
    StDone
  } state_e;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [MAX_W-1:0] vec,
                                               input int unsigned      idx);
    return vec[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/sub_nibble_slice.sv
// Combinational 4-bit ripple slice computing a + ~b + cin; cout=1 means no borrow.
module sub_nibble_slice
  import nibble_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic             c;
  logic [NIB_W-1:0] nb;

  always_comb begin
    nb    = ~b_i;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < NIB_W; i++) begin
      sum_o[i] = a_i[i] ^ nb[i] ^ c;
      c        = (a_i[i] & nb[i]) | (a_i[i] & c) | (nb[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Computes WIDTH-bit a - b one nibble per cycle through a single shared slice.
// Define NIBBLE_SUB_ABS_EN to return |a - b| and add the neg output.
module nibble_serial_sub_ctrl
  import nibble_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             no_borrow,
  output logic             busy
`ifdef NIBBLE_SUB_ABS_EN
  ,
  output logic             neg
`endif
);

  localparam int unsigned NIB  = WIDTH / NIB_W;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              no_borrow_q, no_borrow_d;
  logic [IdxW-1:0]   idx_q, idx_d;
`ifdef NIBBLE_SUB_ABS_EN
  logic              neg_q, neg_d;
`endif

  logic [NIB_W-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cin, slice_cout;
  logic              last_nib;
  logic              accept;

  assign last_nib  = (idx_q == IdxW'(NIB - 1));
  assign in_ready  = rst_n && (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign no_borrow = no_borrow_q;
`ifdef NIBBLE_SUB_ABS_EN
  assign neg       = neg_q;
`endif

  // The NEG pass negates the partial result in place: 0 + ~r + 1.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = carry_q;
    if (state_q == StSub) begin
      slice_a = nib_sel(MAX_W'(a_q), 32'(idx_q));
      slice_b = nib_sel(MAX_W'(b_q), 32'(idx_q));
`ifdef NIBBLE_SUB_ABS_EN
    end else if (state_q == StNeg) begin
      slice_b = nib_sel(MAX_W'(result_q), 32'(idx_q));
`endif
    end
  end

  sub_nibble_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (slice_cin),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    no_borrow_d = no_borrow_q;
    idx_d       = idx_q;
`ifdef NIBBLE_SUB_ABS_EN
    neg_d       = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = StSub;
        end
      end
      StSub: begin
        result_d[idx_q*NIB_W +: NIB_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (last_nib) begin
          no_borrow_d = slice_cout;
          state_d     = StDone;
`ifdef NIBBLE_SUB_ABS_EN
          neg_d = ~slice_cout;
          if (!slice_cout) begin
            carry_d = 1'b1;
            idx_d   = '0;
            state_d = StNeg;
          end
`endif
        end
      end
`ifdef NIBBLE_SUB_ABS_EN
      StNeg: begin
        result_d[idx_q*NIB_W +: NIB_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (last_nib) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      no_borrow_q <= 1'b0;
      idx_q       <= '0;
`ifdef NIBBLE_SUB_ABS_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      no_borrow_q <= no_borrow_d;
      idx_q       <= idx_d;
`ifdef NIBBLE_SUB_ABS_EN
      neg_q       <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Self-checking bench for nibble_serial_sub_ctrl at WIDTH=8 and WIDTH=16.
module tb_nibble_serial_sub_ctrl;

`ifdef NIBBLE_SUB_ABS_EN
  localparam bit AbsEn = 1'b1;
`else
  localparam bit AbsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready8, out_valid8, no_borrow8, busy8;
  logic [7:0] a8 = '0, b8 = '0, result8;
  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic        in_ready16, out_valid16, no_borrow16, busy16;
  logic [15:0] a16 = '0, b16 = '0, result16;
`ifdef NIBBLE_SUB_ABS_EN
  logic neg8, neg16;
`endif

  int checks = 0;
  int failures = 0;

  nibble_serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .result    (result8),
    .no_borrow (no_borrow8),
    .busy      (busy8)
`ifdef NIBBLE_SUB_ABS_EN
    ,
    .neg       (neg8)
`endif
  );

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .result    (result16),
    .no_borrow (no_borrow16),
    .busy      (busy16)
`ifdef NIBBLE_SUB_ABS_EN
    ,
    .neg       (neg16)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic nb, output int lat);
    int unsigned ai, bi, m;
    ai = 32'(a);
    bi = 32'(b);
    m  = (32'd1 << w) - 1;
    nb = (ai >= bi);
    if (AbsEn && !nb) begin
      r   = 16'((bi - ai) & m);
      lat = 2 * (w / 4);
    end else begin
      r   = 16'((ai - bi) & m);
      lat = w / 4;
    end
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] er;
    logic        enb;
    int          elat, cyc;
    model(8, {8'h00, a}, {8'h00, b}, er, enb, elat);
    cyc = 0;
    while (in_ready8 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++; $display("FAIL op8_in_ready: got %b expected 1", in_ready8);
    end
    a8 = a; b8 = b; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (out_valid8 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (cyc !== elat) begin
      failures++; $display("FAIL op8_latency a=%h b=%h: got %0d expected %0d", a, b, cyc, elat);
    end
    checks++;
    if (result8 !== er[7:0]) begin
      failures++; $display("FAIL op8_result a=%h b=%h: got %h expected %h", a, b, result8, er[7:0]);
    end
    checks++;
    if (no_borrow8 !== enb) begin
      failures++; $display("FAIL op8_no_borrow a=%h b=%h: got %b expected %b", a, b, no_borrow8, enb);
    end
`ifdef NIBBLE_SUB_ABS_EN
    checks++;
    if (neg8 !== ~enb) begin
      failures++; $display("FAIL op8_neg a=%h b=%h: got %b expected %b", a, b, neg8, ~enb);
    end
`endif
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL op8_handoff: got out_valid=%b in_ready=%b expected 0 1", out_valid8, in_ready8);
    end
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        enb;
    int          elat, cyc;
    model(16, a, b, er, enb, elat);
    cyc = 0;
    while (in_ready16 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    a16 = a; b16 = b; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    cyc = 0;
    while (out_valid16 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (cyc !== elat) begin
      failures++; $display("FAIL op16_latency a=%h b=%h: got %0d expected %0d", a, b, cyc, elat);
    end
    checks++;
    if (result16 !== er || no_borrow16 !== enb) begin
      failures++;
      $display("FAIL op16_result a=%h b=%h: got %h/%b expected %h/%b",
               a, b, result16, no_borrow16, er, enb);
    end
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL op16_handoff: got out_valid=%b expected 0", out_valid16);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    tick(); tick(); tick();
    checks++;
    if (in_ready8 !== 1'b0 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got in_ready=%b busy=%b out_valid=%b expected 0 0 0",
               in_ready8, busy8, out_valid8);
    end
    checks++;
    if (result8 !== 8'h00 || no_borrow8 !== 1'b0) begin
      failures++; $display("FAIL reset_data: got %h/%b expected 00/0", result8, no_borrow8);
    end
    in_valid8 = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++; $display("FAIL reset_release: got in_ready=%b busy=%b expected 1 0", in_ready8, busy8);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [7] = '{8'h5A, 8'h10, 8'h03, 8'h80, 8'h00, 8'hFF, 8'h7F};
    logic [7:0] vb [7] = '{8'h23, 8'h01, 8'h05, 8'h80, 8'hFF, 8'hFF, 8'h80};
    for (int i = 0; i < 7; i++) do_op8(va[i], vb[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) do_op8(8'($urandom), 8'($urandom));
  endtask

  task automatic test_backpressure();
    a8 = 8'h5A; b8 = 8'h23; in_valid8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'h00;
    checks++;
    if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
      failures++; $display("FAIL bp_sub: got in_ready=%b busy=%b expected 0 1", in_ready8, busy8);
    end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid8 !== 1'b1 || result8 !== 8'h37 || no_borrow8 !== 1'b1 || in_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got ov=%b res=%h nb=%b ir=%b expected 1 37 1 0",
                 i, out_valid8, result8, no_borrow8, in_ready8);
      end
      tick();
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL bp_handoff: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid8, in_ready8, busy8);
    end
    do_op8(8'h10, 8'h01);
  endtask

  task automatic test_reset_midop();
    logic seen;
    a8 = 8'h03; b8 = 8'h05; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy8 !== 1'b0 || out_valid8 !== 1'b0 || result8 !== 8'h00 || no_borrow8 !== 1'b0 ||
        in_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: got busy=%b ov=%b res=%h nb=%b ir=%b expected 0 0 00 0 0",
               busy8, out_valid8, result8, no_borrow8, in_ready8);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++; $display("FAIL midop_release: got in_ready=%b expected 1", in_ready8);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= out_valid8; end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL midop_no_output: got out_valid seen=%b expected 0", seen);
    end
  endtask

  task automatic test_width16();
    do_op16(16'h1234, 16'h0235);
    do_op16(16'h0003, 16'h0005);
    for (int i = 0; i < 10; i++) do_op16(16'($urandom), 16'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
